// File: rtl/density_pkg.sv
// Shared helpers for the density meter: counter width and saturating bound arithmetic.
// The saturating helpers are only exercised when DENSITY_HYST_EN is defined.
package density_pkg;

    function automatic int CNT_W(input int win_log2);
        return win_log2 + 1;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? 32'd0 : a - b;
    endfunction

endpackage

// File: rtl/density_ch.sv
// One density channel: 2-flop synchroniser, window accumulator, result register, compare.
// Optional hysteresis on the decision when DENSITY_HYST_EN is defined.
module density_ch
    import density_pkg::*;
#(
    parameter int WIN_LOG2 = 10
`ifdef DENSITY_HYST_EN
    , parameter int HYST = 0
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig,
    input  logic                last_phase,
    input  logic [WIN_LOG2:0]   thresh,
    output logic [WIN_LOG2:0]   count,
    output logic                cmp
);
    localparam int CW = CNT_W(WIN_LOG2);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] acc_reg;
    logic [CW-1:0] count_reg;
    logic          cmp_reg;
    logic [CW-1:0] sum;
    logic          cmp_next;

    // The last-phase sample goes into the result, so no sample is lost at the boundary.
    assign sum = acc_reg + CW'(sync2_reg);

`ifdef DENSITY_HYST_EN
    logic [CW-1:0] upper;
    logic [CW-1:0] lower;

    assign upper = CW'(sat_add(32'(thresh), 32'(HYST), 32'd1 << WIN_LOG2));
    assign lower = CW'(sat_sub(32'(thresh), 32'(HYST)));

    always_comb begin
        cmp_next = cmp_reg;
        if (sum >= upper) begin
            cmp_next = 1'b1;
        end else if (sum < lower) begin
            cmp_next = 1'b0;
        end
    end
`else
    assign cmp_next = (sum >= thresh);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            acc_reg   <= '0;
            count_reg <= '0;
            cmp_reg   <= 1'b0;
        end else begin
            sync1_reg <= sig;
            sync2_reg <= sync1_reg;
            if (last_phase) begin
                count_reg <= sum;
                acc_reg   <= '0;
                cmp_reg   <= cmp_next;
            end else begin
                acc_reg   <= sum;
            end
        end
    end

    assign count = count_reg;
    assign cmp   = cmp_reg;

endmodule

// File: rtl/density_meter.sv
// Multi-channel bitstream density meter: shared window phase counter plus CH channels.
// Build option: define DENSITY_HYST_EN to add hysteresis (HYST counts) to the decisions.
module density_meter
    import density_pkg::*;
#(
    parameter int CH       = 2,
    parameter int WIN_LOG2 = 10,
    parameter int HYST     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CH-1:0]               sig,
    input  logic [WIN_LOG2:0]           thresh,
    output logic [CH*(WIN_LOG2+1)-1:0]  count,
    output logic                        valid,
    output logic [CH-1:0]               cmp,
    output logic                        oe
);
    localparam int CW = CNT_W(WIN_LOG2);

    logic [WIN_LOG2-1:0] phase_reg;
    logic                valid_reg;
    logic                last_phase;

    if (CH < 1 || WIN_LOG2 < 2 || WIN_LOG2 > 16 || HYST < 0) begin : g_param_err
        $error("density_meter: parameter out of range");
    end

    assign last_phase = &phase_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            phase_reg <= phase_reg + WIN_LOG2'(1);
            valid_reg <= last_phase;
        end
    end

    assign valid = valid_reg;
    assign oe    = phase_reg[WIN_LOG2-1];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            density_ch #(
                .WIN_LOG2   (WIN_LOG2)
`ifdef DENSITY_HYST_EN
                , .HYST     (HYST)
`endif
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .sig        (sig[gi]),
                .last_phase (last_phase),
                .thresh     (thresh),
                .count      (count[gi*CW +: CW]),
                .cmp        (cmp[gi])
            );
        end
    endgenerate

endmodule

// File: doc/density_meter.md
# density_meter

Parametrised multi-channel bitstream density meter for the phase/comparator front end. Each channel synchronises a 1-bit comparator stream, counts ones over a fixed power-of-two window, and publishes the count plus a threshold decision once per window. It supersedes the single-channel free-running counter-plus-MSB output. It sits between the pin-level comparator inputs and the downstream DSP/PWM logic.

## Interface
- `CH`, default 2: number of independent input channels (≥1).
- `WIN_LOG2`, default 10: window length is 2^WIN_LOG2 clock cycles (2..16).
- `HYST`, default 0: hysteresis half-band in counts. Used only when `DENSITY_HYST_EN` is defined.
- `clk`, in, 1: single system clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `sig`, in, CH: raw comparator bits, asynchronous to `clk`.
- `thresh`, in, WIN_LOG2+1: decision threshold in counts, shared by all channels.
- `count`, out, CH*(WIN_LOG2+1): latched per-channel window counts. Channel k occupies bits [k*(WIN_LOG2+1) +: WIN_LOG2+1].
- `valid`, out, 1: one-cycle strobe when `count`/`cmp` update.
- `cmp`, out, CH: per-channel threshold decision.
- `oe`, out, 1: window phase flag; high during the second half of each window.

## Operation
- Input path: 2-flop synchroniser per channel. Only synchronised bits are counted.
- Phase counter: WIN_LOG2 bits, free-running, wraps from 2^WIN_LOG2−1 to 0. No gaps between windows.
- Accumulator per channel, width WIN_LOG2+1, so a full window of ones (2^WIN_LOG2) fits without wrap.
  - On the last phase (all ones): the result register loads accumulator + current sample, and the accumulator clears to 0.
  - Otherwise: the accumulator adds the current sample.
  - No sample is ever dropped at a window boundary.
- `thresh` is sampled on the last-phase cycle only. Changes mid-window have no effect until the next window end.
- `cmp` without hysteresis: `cmp[k]` = (new count ≥ thresh).
- `oe` = phase MSB.

## Timing
- Reset values: phase 0, accumulators 0, synchronisers 0, `count` 0, `valid` 0, `cmp` 0, `oe` 0.
- Input latency: a `sig` edge reaches the accumulator 2 cycles later.
- `valid` is registered. It is high for exactly one cycle, on the cycle after the last phase, which is phase 0 of the next window. `count` and `cmp` change on that same cycle and hold for 2^WIN_LOG2 cycles.
- Windows after reset:
  - The first window starts at reset release.
  - Its count excludes the 2 synchroniser fill cycles, so constant ones give 2^WIN_LOG2−2.
  - All later windows are full.
- Reset asserted mid-window: all state clears immediately. No `valid` is issued for the partial window.
- `oe` toggles at phase 0 and at phase 2^(WIN_LOG2−1).

## Configuration
- `DENSITY_HYST_EN` defined:
  - `cmp[k]` sets when count ≥ thresh+HYST.
  - `cmp[k]` clears when count < thresh−HYST.
  - Between those bounds `cmp[k]` holds.
  - Bounds saturate at 0 and 2^WIN_LOG2.
- `DENSITY_HYST_EN` undefined: plain compare as in Operation. The `HYST` parameter is ignored and no extra state is inferred.

## Structure
- Shared package `density_pkg`:
  - `CNT_W(win_log2)` constant function returning win_log2+1.
  - Saturating add/sub helper used for the hysteresis bounds.
- Sub-module `density_ch`: synchroniser, accumulator, result register and compare for one channel. It takes the shared last-phase flag and the sampled threshold.
- Top-level `density_meter`:
  - Owns the phase counter, `valid` and `oe`.
  - Instantiates CH copies of `density_ch` in a generate loop.

## Test plan
Bench: CH=2, WIN_LOG2=4, HYST=2.
- `sig`=2'b11 constant from reset release → first `valid` gives counts 14/14. All later windows give 16/16, with `valid` every 16 cycles.
- `sig`=2'b00 constant, thresh=0 → counts 0/0, `cmp`=2'b11. Then thresh=1 → `cmp`=2'b00 at the next `valid`.
- ch0 toggles every cycle, ch1 constant 1 → steady-state counts 8/16. With thresh=8, `cmp`=2'b11. With thresh=9, `cmp`=2'b10.
- `rst` pulled low at phase 7 → all outputs read 0 immediately. The first `valid` arrives 16 cycles after release, with no partial-window strobe.
- ch0 window counts driven as 11, 9, 7, 5, thresh=8:
  - With `DENSITY_HYST_EN` defined → `cmp[0]` = 1, 1, 1, 0.
  - Without it → 1, 1, 0, 0.
- `thresh` changed mid-window → the decision reflects only the value present on the last-phase cycle.
